or_m_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one or_m mask-OR datapath (out = a | b) between M requesters.
//  - Each requester presents an operand pair and raises req.
//  - The block grants one requester, captures its operands, drives or_m and returns a registered result.
//  - The result is tagged with the winner's ID under a valid/ready handshake.
//  - Sits between the P02 requester blocks and the single or_m instance.

---
 rtl/or_m_arbiter.sv | 135 +++++++++++++
 tb/tb_or_m_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or_m_arbiter.sv
// Round-robin arbiter sharing one or_m (a | b) datapath between M requesters.
// Grants one requester, captures its operands and returns a tagged result.
module or_m #(
   parameter int N = 4
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] y
);
   assign y = a | b;
endmodule

module or_m_arbiter #(
   parameter int N   = 4,
   parameter int M   = 4,
   parameter int IDW = $clog2(M)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [M-1:0]   req,
   input  logic [M*N-1:0] a_flat,
   input  logic [M*N-1:0] b_flat,
   output logic [M-1:0]   gnt,
   output logic           busy,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_data,
   output logic [IDW-1:0] out_id
);

   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

   localparam logic [IDW:0]   M_W  = (IDW+1)'(M);
   localparam logic [IDW-1:0] LAST = IDW'(M - 1);

   state_t         state, state_n;
   logic [IDW-1:0] ptr, ptr_n;
   logic [IDW-1:0] win_q, win_q_n;
   logic [IDW-1:0] win;
   logic           found;
   logic [N-1:0]   a_q, a_q_n;
   logic [N-1:0]   b_q, b_q_n;
   logic [N-1:0]   or_y;
   logic [M-1:0]   gnt_n;
   logic           out_valid_n;
   logic [N-1:0]   out_data_n;
   logic [IDW-1:0] out_id_n;

   or_m #(.N(N)) u_or (
      .a (a_q),
      .b (b_q),
      .y (or_y)
   );

   // Scan starts just after the last-served requester, wrapping mod M.
   always_comb begin
      logic [IDW:0] sum;
      sum   = '0;
      found = 1'b0;
      win   = '0;
      for (int k = 1; k <= M; k++) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= M_W)
            sum = sum - M_W;
         if (!found && req[sum[IDW-1:0]]) begin
            found = 1'b1;
            win   = sum[IDW-1:0];
         end
      end
   end

   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      win_q_n     = win_q;
      a_q_n       = a_q;
      b_q_n       = b_q;
      gnt_n       = '0;
      out_valid_n = out_valid;
      out_data_n  = out_data;
      out_id_n    = out_id;
      unique case (state)
         IDLE: begin
            if (found) begin
               a_q_n      = a_flat[win*N +: N];
               b_q_n      = b_flat[win*N +: N];
               win_q_n    = win;
               gnt_n[win] = 1'b1;
               state_n    = EXEC;
            end
         end
         EXEC: begin
            out_data_n  = or_y;
            out_id_n    = win_q;
            out_valid_n = 1'b1;
            state_n     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_n = 1'b0;
               ptr_n       = win_q;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         ptr       <= LAST;
         win_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         gnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         win_q     <= win_q_n;
         a_q       <= a_q_n;
         b_q       <= b_q_n;
         gnt       <= gnt_n;
         out_valid <= out_valid_n;
         out_data  <= out_data_n;
         out_id    <= out_id_n;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_or_m_arbiter.sv
// Scoreboard bench for or_m_arbiter: stimulus pushes expected grants/results,
// negedge monitors pop and compare whenever the DUT presents them.
module tb_or_m_arbiter;

   localparam int N   = 4;
   localparam int M   = 4;
   localparam int IDW = 2;

   typedef struct packed {
      logic [N-1:0]   data;
      logic [IDW-1:0] id;
   } res_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [M-1:0]   req;
   logic [M*N-1:0] a_flat;
   logic [M*N-1:0] b_flat;
   logic [M-1:0]   gnt;
   logic           busy;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   out_data;
   logic [IDW-1:0] out_id;

   int tests = 0;
   int fails = 0;

   res_t         res_q[$];
   logic [M-1:0] gnt_q[$];

   or_m_arbiter #(.N(N), .M(M)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .gnt       (gnt),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_id    (out_id)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(int i, logic [N-1:0] a, logic [N-1:0] b);
      a_flat[i*N +: N] = a;
      b_flat[i*N +: N] = b;
   endtask

   task automatic push_res(logic [N-1:0] d, logic [IDW-1:0] id);
      res_t r;
      r.data = d;
      r.id   = id;
      res_q.push_back(r);
   endtask

   task automatic wait_gnt(output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         step();
         if (gnt != '0)
            ok = 1'b1;
      end
      if (!ok) begin
         tests++;
         fails++;
         $display("FAIL gnt_timeout: got no gnt expected one within 20 cycles");
      end
   endtask

   task automatic wait_idle();
      logic done;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         step();
         if (!busy)
            done = 1'b1;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL idle_timeout: busy still 1 expected 0 within 20 cycles");
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      step();
      step();
      rst = 1'b1;
   endtask

   // Result scoreboard: a transfer happens on the next edge.
   always @(negedge clk) begin
      res_t e;
      if (rst && out_valid && out_ready) begin
         if (res_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got data %0h id %0h expected none",
                     out_data, out_id);
         end else begin
            e = res_q.pop_front();
            chk("out_data", 32'(out_data), 32'(e.data));
            chk("out_id", 32'(out_id), 32'(e.id));
         end
      end
   end

   always @(negedge clk) begin
      if (rst && gnt != '0) begin
         if (gnt_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_gnt: got %0h expected none", gnt);
         end else begin
            chk("gnt_order", 32'(gnt), 32'(gnt_q.pop_front()));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic ok;
      rst       = 1'b0;
      req       = '0;
      out_ready = 1'b0;
      a_flat    = '0;
      b_flat    = '0;

      // reset state
      step();
      step();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_id", 32'(out_id), 0);
      rst = 1'b1;
      step();

      // single op
      set_op(0, 4'b1010, 4'b0101);
      out_ready = 1'b1;
      req = 4'b0001;
      gnt_q.push_back(4'b0001);
      push_res(4'b1111, 2'd0);
      step();
      chk("t2_gnt_at_1", 32'(gnt), 32'h1);
      chk("t2_busy_at_1", 32'(busy), 1);
      chk("t2_valid_at_1", 32'(out_valid), 0);
      req = '0;
      step();
      chk("t2_valid_at_2", 32'(out_valid), 1);
      chk("t2_gnt_at_2", 32'(gnt), 0);
      step();
      chk("t2_busy_at_3", 32'(busy), 0);
      chk("t2_valid_at_3", 32'(out_valid), 0);

      // round-robin from a fresh pointer
      do_reset();
      out_ready = 1'b1;
      set_op(0, 4'b0001, 4'b0000);
      set_op(1, 4'b0010, 4'b0100);
      set_op(2, 4'b1000, 4'b1000);
      set_op(3, 4'b1100, 4'b0011);
      gnt_q.push_back(4'b0001);
      gnt_q.push_back(4'b0010);
      gnt_q.push_back(4'b0100);
      gnt_q.push_back(4'b1000);
      gnt_q.push_back(4'b0001);
      push_res(4'b0001, 2'd0);
      push_res(4'b0110, 2'd1);
      push_res(4'b1000, 2'd2);
      push_res(4'b1111, 2'd3);
      push_res(4'b0001, 2'd0);
      req = 4'b1111;
      for (int k = 0; k < 5; k++)
         wait_gnt(ok);
      req = '0;
      wait_idle();

      // back-pressure
      set_op(0, 4'b0011, 4'b1000);
      out_ready = 1'b0;
      req = 4'b0001;
      gnt_q.push_back(4'b0001);
      push_res(4'b1011, 2'd0);
      wait_gnt(ok);
      req = '0;
      step();
      for (int c = 0; c < 5; c++) begin
         req = 4'b1111;
         set_op(0, 4'(c), ~4'(c));
         step();
         chk("bp_data", 32'(out_data), 32'hB);
         chk("bp_id", 32'(out_id), 0);
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_no_gnt", 32'(gnt), 0);
      end
      out_ready = 1'b1;
      step();
      req = '0;
      chk("bp_accepted", 32'(out_valid), 0);
      step();

      // fairness between two requesters
      do_reset();
      set_op(0, 4'b0100, 4'b0001);
      set_op(1, 4'b0000, 4'b1110);
      gnt_q.push_back(4'b0001);
      gnt_q.push_back(4'b0010);
      gnt_q.push_back(4'b0001);
      gnt_q.push_back(4'b0010);
      push_res(4'b0101, 2'd0);
      push_res(4'b1110, 2'd1);
      push_res(4'b0101, 2'd0);
      push_res(4'b1110, 2'd1);
      out_ready = 1'b1;
      req = 4'b0011;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(ok);
         if (gnt[0]) begin
            req[0] = 1'b0;
            step();
            req[0] = 1'b1;
         end
      end
      req = '0;
      wait_idle();

      // operands captured at the grant, not resampled
      set_op(1, 4'b0001, 4'b0010);
      req = 4'b0010;
      gnt_q.push_back(4'b0010);
      push_res(4'b0011, 2'd1);
      wait_gnt(ok);
      set_op(1, 4'b1000, 4'b0010);
      req = '0;
      wait_idle();

      // reset in the middle of HOLD discards the result
      set_op(2, 4'b0110, 4'b0001);
      out_ready = 1'b0;
      req = 4'b0100;
      gnt_q.push_back(4'b0100);
      wait_gnt(ok);
      req = '0;
      step();
      chk("mid_hold_valid", 32'(out_valid), 1);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_gnt", 32'(gnt), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_data", 32'(out_data), 0);
      step();
      rst = 1'b1;
      out_ready = 1'b1;
      set_op(0, 4'b1001, 4'b0100);
      req = 4'b0001;
      gnt_q.push_back(4'b0001);
      push_res(4'b1101, 2'd0);
      wait_gnt(ok);
      chk("post_rst_gnt", 32'(gnt), 32'h1);
      req = '0;
      wait_idle();
      step();
      step();

      chk("res_q_drained", 32'(res_q.size()), 0);
      chk("gnt_q_drained", 32'(gnt_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
